// File: rtl/vegetable_eat_detector_pkg.sv
// Shared constants for the vegetable eat detector: sprite sizes, playfield
// limits and the eat FSM state encoding.
package vegetable_eat_detector_pkg;

    // Sprite extents in pixels (box spans [pos, pos + size] inclusive)
    localparam int VEGETABLE_SIZE = 16;
    localparam int PIG_SIZE       = 32;

    // Playfield limits
    localparam int MIN_X = 0;
    localparam int MAX_X = 639;
    localparam int MIN_Y = 0;
    localparam int MAX_Y = 479;

    // Eat FSM states; the encoding is visible on dbg_state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        EATEN  = 2'd2,
        SETTLE = 2'd3
    } state_e;

endpackage

// File: rtl/vegetable_eat_detector_score_counter.sv
// Saturating score counter for the vegetable eat detector.
// Build option: define SCORE_BCD_EN for a two-digit BCD score (00..99,
// saturating at 0x99); otherwise the score is binary 0..255, saturating at 255.
module score_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] score
);

    logic [7:0] score_q;
    logic [7:0] score_d;

    // Next score: clear wins over increment; increment stops at the ceiling
    always_comb begin
        score_d = score_q;
        if (clr) begin
            score_d = 8'd0;
        end else if (inc) begin
`ifdef SCORE_BCD_EN
            if (score_q != 8'h99) begin
                if (score_q[3:0] == 4'd9) begin
                    score_d = {score_q[7:4] + 4'd1, 4'd0};
                end else begin
                    score_d = {score_q[7:4], score_q[3:0] + 4'd1};
                end
            end
`else
            if (score_q != 8'hFF) begin
                score_d = score_q + 8'd1;
            end
`endif
        end
    end

    // Score register, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q <= 8'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/vegetable_eat_detector.sv
// Vegetable eat detector: detects overlap of the pig box and the vegetable
// box, counts eats, grows the pig and requests a vegetable relocation.
// Build option: SCORE_BCD_EN selects a BCD score in score_counter.
//
// Handshake: there is no back-pressure. new_round is a single-cycle pulse
// that the vegetable locator must act on in the cycle it is high; hits are
// ignored for SETTLE_CYCLES cycles afterwards while the locator moves it.
module vegetable_eat_detector
    import vegetable_eat_detector_pkg::*;
#(
    parameter int GROWTH_STEP   = 4,
    parameter int GROWTH_MAX    = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] pigX,
    input  logic [10:0] pigY,
    input  logic [10:0] vegX,
    input  logic [10:0] vegY,
    input  logic [10:0] vegX_end,
    input  logic [10:0] vegY_end,
    output logic        new_round,
    output logic [10:0] pig_growth,
    output logic [7:0]  score,
    output logic        armed,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        growth_q, growth_d;
    logic               hit_q, hit_d;
    logic               new_round_q, new_round_d;
    logic               armed_q, armed_d;
    logic               score_clr, score_inc;

    logic [11:0]        pig_x_end, pig_y_end;
    logic [11:0]        growth_sum;
    logic [10:0]        growth_capped;

    // Pig box far corner at 12 bits so a pig near the right/bottom edge
    // cannot wrap around and miss
    always_comb begin
        pig_x_end = {1'b0, pigX} + 12'(PIG_SIZE) + {1'b0, growth_q};
        pig_y_end = {1'b0, pigY} + 12'(PIG_SIZE) + {1'b0, growth_q};
        hit_d     = (pigX <= vegX_end) && (pig_x_end >= {1'b0, vegX}) &&
                    (pigY <= vegY_end) && (pig_y_end >= {1'b0, vegY});
    end

    // Growth after one more eat, clamped to GROWTH_MAX
    always_comb begin
        growth_sum    = {1'b0, growth_q} + 12'(GROWTH_STEP);
        growth_capped = (growth_sum >= 12'(GROWTH_MAX)) ? 11'(GROWTH_MAX)
                                                        : growth_sum[10:0];
    end

    // Next state, settle counter, growth and score controls
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        growth_d  = growth_q;
        score_clr = 1'b0;
        score_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARMED;
                    growth_d  = 11'd0;
                    score_clr = 1'b1;
                end
            end
            ARMED: begin
                if (hit_q) begin
                    state_d   = EATEN;
                    growth_d  = growth_capped;
                    score_inc = 1'b1;
                end
            end
            EATEN: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ARMED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        new_round_d = (state_d == EATEN);
        armed_d     = (state_d == ARMED);
    end

    // State, counter, growth, hit and registered output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            growth_q    <= 11'd0;
            hit_q       <= 1'b0;
            new_round_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            growth_q    <= growth_d;
            hit_q       <= hit_d;
            new_round_q <= new_round_d;
            armed_q     <= armed_d;
        end
    end

    score_counter u_score_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (score_clr),
        .inc   (score_inc),
        .score (score)
    );

    assign new_round  = new_round_q;
    assign armed      = armed_q;
    assign pig_growth = growth_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vegetable_eat_detector.sv
// Bench for vegetable_eat_detector (default parameters; honours SCORE_BCD_EN).
module tb_vegetable_eat_detector;
    import vegetable_eat_detector_pkg::*;

    localparam int GS = 4;
    localparam int GM = 64;
`ifdef SCORE_BCD_EN
    localparam int         SAT_EATS  = 99;
    localparam logic [7:0] SAT_SCORE = 8'h99;
`else
    localparam int         SAT_EATS  = 255;
    localparam logic [7:0] SAT_SCORE = 8'hFF;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] pigX, pigY, vegX, vegY, vegX_end, vegY_end;
    logic        new_round;
    logic [10:0] pig_growth;
    logic [7:0]  score;
    logic        armed;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nr_cnt = 0;
    int m_eats = 0;
    logic        prev_nr = 1'b0;
    logic [18:0] mon_e;
    logic [18:0] exp_q[$];

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic [10:0] vx;
        logic [10:0] vy;
        logic        exp_eat;
    } vec_t;
    vec_t tbl[10];

    vegetable_eat_detector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pigX       (pigX),
        .pigY       (pigY),
        .vegX       (vegX),
        .vegY       (vegY),
        .vegX_end   (vegX_end),
        .vegY_end   (vegY_end),
        .new_round  (new_round),
        .pig_growth (pig_growth),
        .score      (score),
        .armed      (armed),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] exp_score(input int n);
        int c;
`ifdef SCORE_BCD_EN
        c = (n > 99) ? 99 : n;
        return 8'(((c / 10) << 4) | (c % 10));
`else
        c = (n > 255) ? 255 : n;
        return 8'(c);
`endif
    endfunction

    function automatic logic [10:0] exp_growth(input int n);
        int g;
        g = n * GS;
        if (g > GM) g = GM;
        return 11'(g);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every new_round pulse pops one expected {score, growth}
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (new_round === 1'b1) begin
            nr_cnt++;
            check("pulse_width", {31'd0, prev_nr}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_new_round actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("eat_score", {24'd0, score}, {24'd0, mon_e[18:11]});
                check("eat_growth", {21'd0, pig_growth}, {21'd0, mon_e[10:0]});
            end
        end
        prev_nr = new_round;
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic park();
        pigX = 11'd100;
        pigY = 11'd100;
    endtask

    task automatic set_veg(input logic [10:0] x, input logic [10:0] y);
        vegX     = x;
        vegY     = y;
        vegX_end = x + 11'(VEGETABLE_SIZE);
        vegY_end = y + 11'(VEGETABLE_SIZE);
    endtask

    task automatic push_eat();
        m_eats++;
        exp_q.push_back({exp_score(m_eats), exp_growth(m_eats)});
    endtask

    task automatic reset_and_start();
        check("pending_eats", exp_q.size(), 0);
        exp_q.delete();
        rst   = 1'b0;
        start = 1'b0;
        step();
        rst    = 1'b1;
        m_eats = 0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("armed_after_start", {31'd0, armed}, 1);
    endtask

    task automatic wait_armed();
        int n;
        n = 0;
        while (armed !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("wait_armed", {31'd0, armed}, 1);
    endtask

    task automatic eat_once();
        int base;
        int n;
        base = nr_cnt;
        n    = 0;
        pigX = 11'd290;
        pigY = 11'd290;
        push_eat();
        while (nr_cnt == base && n < 10) begin
            step();
            n++;
        end
        check("eat_seen", nr_cnt, base + 1);
        park();
        wait_armed();
    endtask

    initial begin
        int base;
        int n;

        tbl[0] = '{11'd100,  11'd100, 11'd300,  11'd300, 1'b0};
        tbl[1] = '{11'd268,  11'd300, 11'd300,  11'd300, 1'b1};
        tbl[2] = '{11'd267,  11'd300, 11'd300,  11'd300, 1'b0};
        tbl[3] = '{11'd316,  11'd316, 11'd300,  11'd300, 1'b1};
        tbl[4] = '{11'd317,  11'd300, 11'd300,  11'd300, 1'b0};
        tbl[5] = '{11'd300,  11'd268, 11'd300,  11'd300, 1'b1};
        tbl[6] = '{11'd300,  11'd267, 11'd300,  11'd300, 1'b0};
        tbl[7] = '{11'd300,  11'd317, 11'd300,  11'd300, 1'b0};
        tbl[8] = '{11'd2030, 11'd100, 11'd2031, 11'd100, 1'b1};
        tbl[9] = '{11'd290,  11'd290, 11'd300,  11'd300, 1'b1};

        // Reset values
        rst   = 1'b1;
        start = 1'b0;
        park();
        set_veg(11'd300, 11'd300);
        #1 rst = 1'b0;
        #1;
        check("rst_new_round", {31'd0, new_round}, 0);
        check("rst_armed", {31'd0, armed}, 0);
        check("rst_score", {24'd0, score}, 0);
        check("rst_growth", {21'd0, pig_growth}, 0);
        check("rst_state", {30'd0, dbg_state}, IDLE);
        step();
        rst = 1'b1;
        steps(2);
        check("idle_without_start", {30'd0, dbg_state}, IDLE);

        // Armed with no overlap: fixed then random far-away positions
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i < 10) begin
                park();
            end else if ($urandom_range(1, 0) == 0) begin
                pigX = 11'($urandom_range(200, MIN_X));
                pigY = 11'($urandom_range(MAX_Y, MIN_Y));
            end else begin
                pigX = 11'($urandom_range(MAX_X, 317));
                pigY = 11'($urandom_range(MAX_Y, MIN_Y));
            end
            step();
        end
        park();
        step();
        check("miss_pulses", nr_cnt, 0);
        check("miss_score", {24'd0, score}, 0);
        check("miss_armed", {31'd0, armed}, 1);

        // Table of box-boundary cases, each from a fresh game
        foreach (tbl[i]) begin
            reset_and_start();
            base = nr_cnt;
            set_veg(tbl[i].vx, tbl[i].vy);
            pigX = tbl[i].px;
            pigY = tbl[i].py;
            if (tbl[i].exp_eat) push_eat();
            steps(4);
            check($sformatf("tbl%0d_pulses", i), nr_cnt - base, {31'd0, tbl[i].exp_eat});
            check($sformatf("tbl%0d_score", i), {24'd0, score}, {24'd0, exp_score(m_eats)});
            park();
        end
        set_veg(11'd300, 11'd300);

        // Latency and re-eat spacing under a continuous overlap
        reset_and_start();
        base = nr_cnt;
        push_eat();
        push_eat();
        pigX = 11'd290;
        pigY = 11'd290;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("timing_edge%0d", i), {31'd0, new_round}, {31'd0, (i == 2 || i == 8)});
        end
        park();
        wait_armed();
        check("timing_pulses", nr_cnt - base, 2);

        // Growth saturation over 17 eats
        reset_and_start();
        for (int i = 0; i < 17; i++) eat_once();
        check("growth_17", {21'd0, pig_growth}, GM);
        check("score_17", {24'd0, score}, {24'd0, exp_score(17)});

        // Score saturation
        while (m_eats < SAT_EATS + 2) eat_once();
        check("score_sat", {24'd0, score}, {24'd0, SAT_SCORE});
        check("growth_sat", {21'd0, pig_growth}, GM);

        // start ignored outside IDLE, then reset mid-SETTLE
        reset_and_start();
        eat_once();
        start = 1'b1;
        steps(3);
        check("start_armed_score", {24'd0, score}, {24'd0, exp_score(1)});
        check("start_armed_state", {30'd0, dbg_state}, ARMED);
        start = 1'b0;
        pigX  = 11'd290;
        pigY  = 11'd290;
        push_eat();
        n = 0;
        while (dbg_state !== SETTLE && n < 10) begin
            step();
            n++;
        end
        check("reach_settle", {30'd0, dbg_state}, SETTLE);
        park();
        step();
        #1 rst = 1'b0;
        #1;
        check("async_new_round", {31'd0, new_round}, 0);
        check("async_armed", {31'd0, armed}, 0);
        check("async_score", {24'd0, score}, 0);
        check("async_growth", {21'd0, pig_growth}, 0);
        check("async_state", {30'd0, dbg_state}, IDLE);
        m_eats = 0;
        base   = nr_cnt;
        step();
        rst = 1'b1;
        steps(12);
        check("no_pulse_after_reset", nr_cnt, base);
        check("idle_after_reset", {30'd0, dbg_state}, IDLE);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vegetable_eat_detector.md
VEGETABLE_EAT_DETECTOR -- requirements
Module: vegetable_eat_detector

Interface
REQ-001 The block SHALL have parameter GROWTH_STEP, default 4, which is the pig_growth increment per vegetable eaten.
REQ-002 The block SHALL have parameter GROWTH_MAX, default 64, which is the saturation ceiling of pig_growth.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 4, which is the number of cycles hits are ignored after an eat.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: game start; level-sampled each cycle.
REQ-007 The block SHALL have ports pigX and pigY, input, 11 bits each: pig top-left corner.
REQ-008 The block SHALL have ports vegX and vegY, input, 11 bits each: vegetable top-left corner, from the vegetable locator.
REQ-009 The block SHALL have ports vegX_end and vegY_end, input, 11 bits each: vegetable bottom-right corner, from the vegetable locator.
REQ-010 The block SHALL have port new_round, output, 1 bit: one-cycle pulse requesting a vegetable relocation.
REQ-011 The block SHALL have port pig_growth, output, 11 bits: added pig extent in pixels, fed back to the locator.
REQ-012 The block SHALL have port score, output, 8 bits: vegetables eaten (encoding per REQ-030/031).
REQ-013 The block SHALL have port armed, output, 1 bit: high when the FSM is in ARMED.

Function
REQ-014 The block SHALL treat the pig box as X in [pigX, pigX+pig_size+pig_growth] and Y in [pigY, pigY+pig_size+pig_growth], bounds inclusive.
REQ-015 The block SHALL compute the pig box sums at 12-bit width, with no wrap.
REQ-016 The block SHALL compute hit = (pigX <= vegX_end) && (pigX_end >= vegX) && (pigY <= vegY_end) && (pigY_end >= vegY).
REQ-017 The block SHALL register hit into hit_q every cycle.
REQ-018 The FSM SHALL have exactly the states IDLE, ARMED, EATEN and SETTLE.
REQ-019 In IDLE, start=1 SHALL move the FSM to ARMED and clear score and pig_growth on the same edge.
REQ-020 In ARMED, hit_q=1 SHALL move the FSM to EATEN; otherwise the FSM SHALL stay in ARMED.
REQ-021 On the edge entering EATEN, score SHALL increment and pig_growth SHALL become min(pig_growth+GROWTH_STEP, GROWTH_MAX).
REQ-022 new_round SHALL be a registered output, high exactly in the EATEN cycle, i.e. exactly one clock.
REQ-023 Latency SHALL be: overlap present at edge N, then new_round high in the cycle following edge N+1.
REQ-024 EATEN SHALL go unconditionally to SETTLE and load the settle counter with SETTLE_CYCLES-1.
REQ-025 SETTLE SHALL decrement the counter; at 0 it SHALL go to ARMED; hit_q SHALL be ignored in SETTLE.
REQ-026 start asserted outside IDLE SHALL be ignored, with no clear and no state change.
REQ-027 A continuous overlap lasting through SETTLE SHALL produce a second eat on the first ARMED cycle in which hit_q=1.
REQ-028 Growth already at GROWTH_MAX SHALL hold pig_growth; score SHALL still increment.

Reset
REQ-029 On rst=0, asynchronously: the FSM SHALL enter IDLE; new_round=0, armed=0, score=0, pig_growth=0, hit_q=0 and the settle counter=0. A reset mid-SETTLE SHALL abort with no pending pulse.

Configuration
REQ-030 With SCORE_BCD_EN defined, score SHALL be two BCD digits, [7:4] tens and [3:0] units, counting 00..99 and saturating at 0x99.
REQ-031 With SCORE_BCD_EN not defined, score SHALL be binary 0..255, saturating at 255.

Structure
REQ-032 vegetable_size, pig_size, minX/maxX/minY/maxY and the FSM state encodings SHALL live in the shared constants include.
REQ-033 The score counter, binary or BCD under the macro, SHALL be one sub-module named score_counter with ports clk, rst, clr, inc, score.

Verification
REQ-034 Scenario: reset, start=1 for 1 cycle, then pig (100,100) and veg (300,300)-(316,316) for 50 cycles; the bench SHALL see new_round=0, score=0, armed=1.
REQ-035 Scenario: in ARMED, set pig=(290,290) with pig_size=32; the bench SHALL see a new_round pulse exactly 2 edges later, width 1, score=1, pig_growth=4.
REQ-036 Scenario: hold the overlap constant; the bench SHALL see the next new_round exactly SETTLE_CYCLES+2 cycles after the first.
REQ-037 Scenario: 17 eats with GROWTH_MAX=64; the bench SHALL see pig_growth=64 from eat 16 onward and score=17 (0x17 when BCD).
REQ-038 Scenario: score at 99 with BCD enabled, then eat; the bench SHALL see score stay 0x99. Score at 255 with BCD disabled, then eat; the bench SHALL see score stay 255.
REQ-039 Scenario: assert rst=0 mid-SETTLE without a clock edge; the bench SHALL see outputs at reset values immediately, and start=1 in ARMED SHALL not clear score.
